// File: rtl/quantum_scheduler.sv
// Multi-process preemption timer: per-slot quantum and active bit, round-robin slot
// selection, and a one-cycle interrupt whenever the running slot expires or finishes.
module quantum_scheduler #(
    parameter int WORD_SIZE       = 32,
    parameter int NUM_PROC        = 4,
    parameter int PID_WIDTH       = 2,
    parameter int DEFAULT_QUANTUM = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] quantum,
    input  logic [PID_WIDTH-1:0] pid_sel,
    input  logic                 FLAG_timer,
    input  logic                 FLAG_start,
    input  logic                 finish,
    input  logic                 halt,
    input  logic                 FLAG_input,
    input  logic                 FLAG_output,
    output logic                 interrupt,
    output logic [PID_WIDTH-1:0] current_pid,
    output logic [NUM_PROC-1:0]  active_mask,
    output logic                 running,
    output logic [WORD_SIZE-1:0] remaining,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] quanta [NUM_PROC];
    logic                 pause;
    logic                 finish_event;
    logic                 expiry;
    logic [PID_WIDTH-1:0] start_pid;
    logic [PID_WIDTH-1:0] next_pid;

    assign fsm_state    = state;
    assign pause        = halt | FLAG_input | FLAG_output;
    // Writing a zero quantum to the running slot retires it just like finish.
    assign finish_event = finish | (FLAG_timer && (pid_sel == current_pid) && (quantum == '0));
    assign expiry       = (remaining == WORD_SIZE'(1)) && !pause;

    always_comb begin
        start_pid = '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (active_mask[PID_WIDTH'(i)]) start_pid = PID_WIDTH'(i);
        end
        if (active_mask[pid_sel]) start_pid = pid_sel;
    end

    // First active slot after current_pid; current_pid itself is the last candidate.
    always_comb begin : next_sel
        int   j;
        logic found;
        next_pid = current_pid;
        found    = 1'b0;
        j        = 0;
        for (int i = 1; i <= NUM_PROC; i++) begin
            j = int'(current_pid) + i;
            if (j >= NUM_PROC) j = j - NUM_PROC;
            if (!found && active_mask[PID_WIDTH'(j)]) begin
                next_pid = PID_WIDTH'(j);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            interrupt   <= 1'b0;
            running     <= 1'b0;
            current_pid <= '0;
            active_mask <= '0;
            remaining   <= '0;
            for (int i = 0; i < NUM_PROC; i++) quanta[i] <= WORD_SIZE'(DEFAULT_QUANTUM);
        end else begin
            interrupt <= 1'b0;
            if (FLAG_timer) begin
                quanta[pid_sel]      <= quantum;
                active_mask[pid_sel] <= (quantum != '0);
            end
            case (state)
                IDLE: begin
                    if (FLAG_start && (active_mask != '0)) begin
                        current_pid <= start_pid;
                        remaining   <= quanta[start_pid];
                        running     <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (!pause && (remaining != '0)) remaining <= remaining - WORD_SIZE'(1);
                    if (finish_event) begin
                        // Placed after the FLAG_timer write so the clear always wins.
                        active_mask[current_pid] <= 1'b0;
                        interrupt                <= 1'b1;
                        running                  <= 1'b0;
                        state                    <= SWITCH;
                    end else if (expiry) begin
                        interrupt <= 1'b1;
                        running   <= 1'b0;
                        state     <= SWITCH;
                    end
                end
                SWITCH: begin
                    if (active_mask != '0) begin
                        current_pid <= next_pid;
                        remaining   <= quanta[next_pid];
                        running     <= 1'b1;
                        state       <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    running <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed bench for quantum_scheduler: a phase-level reference model checked every
// cycle, plus hand-computed literal expectations for each scheduling scenario.
module tb_quantum_scheduler;

    localparam int NP = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] quantum = '0;
    logic [1:0]  pid_sel = '0;
    logic        FLAG_timer = 1'b0;
    logic        FLAG_start = 1'b0;
    logic        finish = 1'b0;
    logic        halt = 1'b0;
    logic        FLAG_input = 1'b0;
    logic        FLAG_output = 1'b0;
    logic        interrupt;
    logic [1:0]  current_pid;
    logic [3:0]  active_mask;
    logic        running;
    logic [31:0] remaining;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad   = 0;

    quantum_scheduler #(
        .WORD_SIZE(32), .NUM_PROC(NP), .PID_WIDTH(2), .DEFAULT_QUANTUM(16)
    ) dut (
        .clock(clock), .reset(reset), .quantum(quantum), .pid_sel(pid_sel),
        .FLAG_timer(FLAG_timer), .FLAG_start(FLAG_start), .finish(finish),
        .halt(halt), .FLAG_input(FLAG_input), .FLAG_output(FLAG_output),
        .interrupt(interrupt), .current_pid(current_pid), .active_mask(active_mask),
        .running(running), .remaining(remaining), .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 running a slice, 2 switching.
    int unsigned m_q[NP];
    bit          m_act[NP];
    int          m_pid;
    int unsigned m_rem;
    int          m_phase;

    task automatic model_step();
        int unsigned q_old[NP];
        bit          act_old[NP];
        bit          any_act;
        bit          stalled;
        bit          fin;
        bit          exp_hit;
        int          pick;
        q_old   = m_q;
        act_old = m_act;
        any_act = 1'b0;
        for (int k = 0; k < NP; k++) if (act_old[k]) any_act = 1'b1;
        stalled = halt | FLAG_input | FLAG_output;
        if (FLAG_timer) begin
            m_q[pid_sel]   = quantum;
            m_act[pid_sel] = (quantum != 0);
        end
        case (m_phase)
            0: if (FLAG_start && any_act) begin
                pick = -1;
                if (act_old[pid_sel]) pick = int'(pid_sel);
                else for (int k = 0; k < NP; k++) if (pick < 0 && act_old[k]) pick = k;
                m_pid   = pick;
                m_rem   = q_old[pick];
                m_phase = 1;
            end
            1: begin
                fin     = finish || (FLAG_timer && int'(pid_sel) == m_pid && quantum == 0);
                exp_hit = (m_rem == 1) && !stalled;
                if (!stalled && m_rem > 0) m_rem = m_rem - 1;
                if (fin) begin
                    m_act[m_pid] = 1'b0;
                    m_phase      = 2;
                end else if (exp_hit) begin
                    m_phase = 2;
                end
            end
            default: if (any_act) begin
                pick = -1;
                for (int k = 1; k <= NP; k++) if (pick < 0 && act_old[(m_pid + k) % NP]) pick = (m_pid + k) % NP;
                m_pid   = pick;
                m_rem   = q_old[pick];
                m_phase = 1;
            end else begin
                m_phase = 0;
            end
        endcase
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NP; k++) begin
                m_q[k]   = 16;
                m_act[k] = 1'b0;
            end
            m_pid   = 0;
            m_rem   = 0;
            m_phase = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clock) begin
        logic [3:0] exp_mask;
        for (int k = 0; k < NP; k++) exp_mask[k] = m_act[k];
        check("interrupt", 32'(interrupt), 32'(m_phase == 2));
        check("running", 32'(running), 32'(m_phase == 1));
        check("current_pid", 32'(current_pid), 32'(m_pid));
        check("active_mask", 32'(active_mask), 32'(exp_mask));
        check("remaining", remaining, m_rem);
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write_q(int pid, int q);
        FLAG_timer = 1'b1;
        pid_sel    = 2'(pid);
        quantum    = 32'(q);
        cyc();
        FLAG_timer = 1'b0;
    endtask

    task automatic start(int pid);
        FLAG_start = 1'b1;
        pid_sel    = 2'(pid);
        cyc();
        FLAG_start = 1'b0;
    endtask

    initial begin
        int irq_count;
        cyc(2);
        check("rst_running", 32'(running), 0);
        check("rst_remaining", remaining, 0);
        check("rst_active", 32'(active_mask), 0);
        check("rst_pid", 32'(current_pid), 0);
        check("rst_interrupt", 32'(interrupt), 0);
        reset = 1'b1;

        // Two slots with q=3 alternate: 3 RUN cycles, 1 SWITCH cycle.
        write_q(0, 3);
        write_q(2, 3);
        check("s1_mask", 32'(active_mask), 32'h5);
        start(0);
        check("s1_pid0", 32'(current_pid), 0);
        check("s1_rem3", remaining, 3);
        cyc(3);
        check("s1_irq", 32'(interrupt), 1);
        check("s1_sw_rem", remaining, 0);
        cyc();
        check("s1_pid2", 32'(current_pid), 2);
        check("s1_pid2_rem", remaining, 3);
        cyc(3);
        check("s1_irq2", 32'(interrupt), 1);
        cyc();
        check("s1_back_pid0", 32'(current_pid), 0);

        // New quantum for the running slot applies only at its next reload; stall freezes count.
        write_q(0, 5);
        check("s2_slice_kept", remaining, 2);
        cyc(7);
        check("s2_pid0", 32'(current_pid), 0);
        check("s2_rem5", remaining, 5);
        cyc();
        FLAG_input = 1'b1;
        cyc(4);
        FLAG_input = 1'b0;
        check("s2_frozen", remaining, 4);
        cyc(3);
        check("s2_no_early_irq", 32'(interrupt), 0);
        cyc();
        check("s2_late_irq", 32'(interrupt), 1);
        cyc();
        check("s2_pid2", 32'(current_pid), 2);

        // Finish coinciding with expiry: one interrupt, slot retired.
        cyc(2);
        check("s3_rem1", remaining, 1);
        finish = 1'b1;
        cyc();
        finish = 1'b0;
        check("s3_irq", 32'(interrupt), 1);
        check("s3_mask", 32'(active_mask), 32'h1);
        cyc();
        check("s3_single_irq", 32'(interrupt), 0);
        check("s3_pid0", 32'(current_pid), 0);
        check("s3_rem5", remaining, 5);

        // Retire pid0, then run pid3 alone with q=2.
        finish = 1'b1;
        cyc();
        finish = 1'b0;
        cyc();
        check("s4_idle_running", 32'(running), 0);
        check("s4_idle_mask", 32'(active_mask), 0);
        start(0);
        check("s4_empty_start", 32'(running), 0);
        write_q(3, 2);
        start(1);
        check("s4_pid3", 32'(current_pid), 3);
        check("s4_rem2", remaining, 2);
        irq_count = 0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (interrupt) irq_count++;
        end
        check("s4_irq_every3", 32'(irq_count), 3);
        check("s4_pid3_again", 32'(current_pid), 3);
        finish = 1'b1;
        cyc();
        finish = 1'b0;
        check("s4_fin_irq", 32'(interrupt), 1);
        check("s4_fin_mask", 32'(active_mask), 0);
        cyc();
        check("s4_to_idle", 32'(running), 0);
        check("s4_no_irq", 32'(interrupt), 0);

        // Quantum rewrite during a pid1 slice, pauses, ignored start, zero-write finish.
        write_q(1, 4);
        write_q(2, 3);
        start(1);
        check("s5_rem4", remaining, 4);
        cyc();
        write_q(1, 7);
        check("s5_slice_kept", remaining, 2);
        cyc(7);
        check("s5_pid1", 32'(current_pid), 1);
        check("s5_rem7", remaining, 7);
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        FLAG_output = 1'b1;
        cyc();
        FLAG_output = 1'b0;
        check("s5_paused", remaining, 7);
        cyc();
        start(2);
        check("s5_start_ignored", 32'(current_pid), 1);
        check("s5_rem5", remaining, 5);
        halt = 1'b1;
        write_q(1, 0);
        halt = 1'b0;
        check("s5_zero_irq", 32'(interrupt), 1);
        check("s5_zero_mask", 32'(active_mask), 32'h4);
        cyc();
        check("s5_pid2", 32'(current_pid), 2);
        check("s5_pid2_rem", remaining, 3);

        // Asynchronous reset between clock edges.
        cyc();
        #2;
        reset = 1'b0;
        #1;
        check("s6_running", 32'(running), 0);
        check("s6_remaining", remaining, 0);
        check("s6_mask", 32'(active_mask), 0);
        check("s6_pid", 32'(current_pid), 0);
        check("s6_interrupt", 32'(interrupt), 0);
        cyc();
        reset = 1'b1;

        // Quantum of 1: one RUN cycle per slice.
        write_q(1, 1);
        write_q(2, 1);
        start(2);
        check("q1_pid2", 32'(current_pid), 2);
        check("q1_rem1", remaining, 1);
        cyc();
        check("q1_irq", 32'(interrupt), 1);
        check("q1_rem0", remaining, 0);
        cyc();
        check("q1_pid1", 32'(current_pid), 1);
        check("q1_run", 32'(running), 1);
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
